// File: rtl/beamformer_pkg.sv
// Shared constants and the steering-delay helper for the 16-mic PDM beamformer.
package beamformer_pkg;

  localparam int unsigned ClkDivDefault = 4;
  localparam int unsigned DecimDefault  = 16;
  localparam int unsigned DelayDepth    = 32;
  localparam int unsigned NumMics       = 16;
  localparam int unsigned DelayW        = 5;
  localparam int unsigned AccW          = 9;

  // Steering delay for one mic: (|s| * (s >= 0 ? mic : 15 - mic)) >> 2, range 0..30.
  function automatic logic [DelayW-1:0] mic_delay(input logic signed [3:0] steer,
                                                 input int unsigned mic);
    logic [3:0] mag;
    logic [3:0] weight;
    logic [7:0] prod;
    // -(-8) wraps to 4'b1000, which read as unsigned is the wanted magnitude 8
    mag    = steer[3] ? 4'(-steer) : 4'(steer);
    weight = steer[3] ? 4'(15 - mic) : 4'(mic);
    prod   = 8'(mag) * 8'(weight);
    return prod[6:2];
  endfunction

endpackage

// File: rtl/mic_delay_line.sv
// One mic's 32-deep PDM history; the tap reads the line as it will be after this shift.
module mic_delay_line
  import beamformer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_shift,
  input  logic              i_sample,
  input  logic [DelayW-1:0] i_delay,
  output logic              o_tap
);

  logic [DelayDepth-1:0] r_line;
  logic [DelayDepth-1:0] w_next;
  logic                  unused_oldest;

  assign w_next        = {r_line[DelayDepth-2:0], i_sample};
  assign o_tap         = w_next[i_delay];
  assign unused_oldest = r_line[DelayDepth-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line <= '0;
    end else if (i_shift) begin
      r_line <= w_next;
    end
  end

endmodule

// File: rtl/tt_um_16_mic_beamformer_arghunter.sv
// 16-mic delay-and-sum PDM beamformer with per-window popcount decimation.
// Define BEAM_SATURATE_EN to clamp the output at 255 instead of dropping the LSB.
module tt_um_16_mic_beamformer_arghunter
  import beamformer_pkg::*;
#(
  parameter int unsigned CLK_DIV = ClkDivDefault,
  parameter int unsigned DECIM   = DecimDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW   = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int unsigned FrameW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CntW-1:0]   CntHalf   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]   CntMid    = CntW'(CLK_DIV);
  localparam logic [CntW-1:0]   CntLast   = CntW'(2 * CLK_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(DECIM - 1);

  logic [CntW-1:0]       r_cnt;
  logic [7:0]            r_even;
  logic signed [3:0]     r_steer;
  logic [AccW-1:0]       r_acc;
  logic [FrameW-1:0]     r_frame;
  logic [7:0]            r_sample;
  logic                  r_strobe;

  logic                  w_frame_evt;
  logic                  w_window_done;
  logic                  w_pdm_clk;
  logic [NumMics-1:0]    w_mics;
  logic [NumMics-1:0]    w_tap;
  logic [DelayW-1:0]     w_delay [NumMics];
  logic [4:0]            w_pop;
  logic [AccW-1:0]       w_total;
  logic [7:0]            w_sample;
  logic                  unused_uio_in;

  assign w_frame_evt   = (r_cnt == CntLast);
  assign w_window_done = w_frame_evt && (r_frame == FrameLast);
  assign w_pdm_clk     = (r_cnt >= CntMid);
  assign unused_uio_in = ^uio_in[3:0];

  for (genvar gk = 0; gk < 8; gk++) begin : g_pair
    assign w_mics[2*gk]   = r_even[gk];
    assign w_mics[2*gk+1] = ui_in[gk];
  end

  for (genvar gi = 0; gi < NumMics; gi++) begin : g_mic
    assign w_delay[gi] = mic_delay(r_steer, gi);

    mic_delay_line u_line (
      .i_clk    (clk),
      .i_rst    (rst_n),
      .i_shift  (ena & w_frame_evt),
      .i_sample (w_mics[gi]),
      .i_delay  (w_delay[gi]),
      .o_tap    (w_tap[gi])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NumMics; i++) begin
      w_pop = w_pop + 5'(w_tap[i]);
    end
  end

  assign w_total = r_acc + AccW'(w_pop);

`ifdef BEAM_SATURATE_EN
  assign w_sample = w_total[8] ? 8'hFF : w_total[7:0];
`else
  assign w_sample = w_total[8:1];
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt    <= '0;
      r_even   <= '0;
      r_steer  <= '0;
      r_acc    <= '0;
      r_frame  <= '0;
      r_sample <= '0;
      r_strobe <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; it never lingers across a stall.
      r_strobe <= 1'b0;
      if (ena) begin
        r_cnt <= w_frame_evt ? '0 : r_cnt + 1'b1;
        if (r_cnt == CntHalf) begin
          r_even <= ui_in;
        end
        if (w_window_done) begin
          r_sample <= w_sample;
          r_acc    <= '0;
          r_frame  <= '0;
          r_steer  <= uio_in[7:4];
          r_strobe <= 1'b1;
        end else if (w_frame_evt) begin
          r_acc   <= w_total;
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  assign uo_out  = r_sample;
  assign uio_out = {6'b0, r_strobe, w_pdm_clk};
  assign uio_oe  = 8'h03;

endmodule

// File: tb/tb_tt_um_16_mic_beamformer_arghunter.sv
// Directed self-checking bench for the 16-mic beamformer (default CLK_DIV/DECIM).
module tb_tt_um_16_mic_beamformer_arghunter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_16_mic_beamformer_arghunter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Output byte for a window total under the configured output mapping.
  function automatic int exp_out(input int total);
`ifdef BEAM_SATURATE_EN
    return (total > 255) ? 255 : total;
`else
    return (total >> 1) & 255;
`endif
  endfunction

  // Counts negedges until the strobe is seen; a missing strobe is reported.
  task automatic wait_strobe(output int cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uio_out[1] && n < 2000);
    if (!uio_out[1]) check_eq("strobe_timeout", 0, 1);
    cycles = n;
  endtask

  // Drives `pattern` only during the last frame of the window started by the last strobe.
  task automatic impulse_window(input logic [7:0] pattern, output int cycles);
    int c;
    repeat (120) @(negedge clk);
    ui_in = pattern;
    wait_strobe(c);
    ui_in = 8'h00;
    cycles = 120 + c;
  endtask

  initial begin
    int cyc;
    int changes;
    int pat;
    logic [7:0] snap_uo;
    logic [7:0] snap_uio;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_uo_out", int'(uo_out), 0);
    check_eq("reset_uio_out", int'(uio_out), 0);
    check_eq("reset_uio_oe", int'(uio_oe), 8'h03);

    // All mics high, s=0
    ui_in = 8'hFF;
    rst_n = 1'b0;
    wait_strobe(cyc);
    check_eq("first_strobe_latency", cyc, 128);
    check_eq("all_high_win1", int'(uo_out), exp_out(256));
    @(negedge clk);
    check_eq("strobe_width", int'(uio_out[1]), 0);
    repeat (60) @(negedge clk);
    check_eq("uo_hold_between", int'(uo_out), exp_out(256));
    wait_strobe(cyc);
    check_eq("strobe_period", cyc + 61, 128);
    check_eq("all_high_win2", int'(uo_out), exp_out(256));

    // Mics 0..7 high
    ui_in = 8'h0F;
    wait_strobe(cyc);
    check_eq("half_high", int'(uo_out), exp_out(128));

    // Freeze 200 cycles mid-window
    repeat (40) @(negedge clk);
    ena      = 1'b0;
    snap_uo  = uo_out;
    snap_uio = uio_out;
    changes  = 0;
    repeat (200) begin
      @(negedge clk);
      if (uo_out != snap_uo || uio_out != snap_uio) changes++;
    end
    check_eq("freeze_changes", changes, 0);
    ena = 1'b1;
    wait_strobe(cyc);
    check_eq("freeze_strobe_delay", cyc + 240, 328);
    check_eq("freeze_value", int'(uo_out), exp_out(128));

    // All low
    ui_in = 8'h00;
    wait_strobe(cyc);
    check_eq("all_low", int'(uo_out), 0);

    // pdm_clk: low for 4 clk after the frame wrap, then high for 4
    pat = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      pat = pat | (int'(uio_out[0]) << i);
    end
    check_eq("pdm_clk_pattern", pat, 8'hF0);
    wait_strobe(cyc);
    check_eq("pdm_window_period", cyc + 7, 128);

    // Impulse in last frame, s=0
    impulse_window(8'hFF, cyc);
    check_eq("imp_s0_latency", cyc, 128);
    check_eq("imp_s0_win1", int'(uo_out), exp_out(16));
    uio_in = 8'h40;
    wait_strobe(cyc);
    check_eq("imp_s0_win2", int'(uo_out), 0);

    // Impulse in last frame, s=4 (d_i = i)
    impulse_window(8'hFF, cyc);
    check_eq("imp_s4_win1", int'(uo_out), exp_out(1));
    uio_in = 8'hC0;
    wait_strobe(cyc);
    check_eq("imp_s4_win2", int'(uo_out), exp_out(15));

    // Impulse on mics 14/15 only, s=-4 (d_15=0, d_14=1)
    impulse_window(8'h80, cyc);
    check_eq("imp_sm4_win1", int'(uo_out), exp_out(1));
    uio_in = 8'h00;
    wait_strobe(cyc);
    check_eq("imp_sm4_win2", int'(uo_out), exp_out(1));

    // Reset mid-window abandons the partial window
    ui_in = 8'hFF;
    wait_strobe(cyc);
    repeat (50) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midreset_uo_out", int'(uo_out), 0);
    check_eq("midreset_uio_out", int'(uio_out), 0);
    rst_n = 1'b0;
    wait_strobe(cyc);
    check_eq("midreset_latency", cyc, 128);
    check_eq("midreset_value", int'(uo_out), exp_out(256));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_16_mic_beamformer_arghunter.md
TT_UM_16_MIC_BEAMFORMER_ARGHUNTER -- requirements
Module: tt_um_16_mic_beamformer_arghunter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per PDM clock half-period.
REQ-002 SHALL have parameter DECIM, default 16: PDM frames per output sample.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-high reset (name kept from the standard tile port list).
REQ-006 SHALL have port ena  input  1  enable; low freezes all state.
REQ-007 SHALL have port ui_in  input  8  PDM data lines; line k carries mic 2k and mic 2k+1.
REQ-008 SHALL have port uio_in  input  8  bits[7:4] steer value s (signed, -8..7); bits[3:0] unused.
REQ-009 SHALL have port uo_out  output  8  beamformed output sample.
REQ-010 SHALL have port uio_out  output  8  bit0 pdm_clk, bit1 sample strobe, bits[7:2] = 0.
REQ-011 SHALL have port uio_oe  output  8  constant 8'h03.

Function
REQ-012 SHALL run PDM counter cnt 0..2*CLK_DIV-1, wrapping; pdm_clk = (cnt >= CLK_DIV).
REQ-013 SHALL latch ui_in[k] as mic 2k at cnt == CLK_DIV-1 and take ui_in[k] as mic 2k+1 at cnt == 2*CLK_DIV-1.
REQ-014 SHALL, at cnt == 2*CLK_DIV-1 (frame event), shift the 16-bit frame into 16 per-mic 32-bit delay lines; tap 0 = newest sample.
REQ-015 SHALL compute delay d_i = (|s| * (s >= 0 ? i : 15-i)) >> 2 for mic i, range 0..30.
REQ-016 SHALL compute per frame pop = number of ones among tap d_i of each mic i (0..16).
REQ-017 SHALL accumulate pop over DECIM frames in a 9-bit accumulator (max 256).
REQ-018 SHALL, on the frame completing a window, drive uo_out with that window's total (pop of the completing frame included), restart the accumulator from zero, and pulse uio_out[1] high for exactly one clk.
REQ-019 SHALL latch s from uio_in[7:4] only at window completion; the new delays apply from the next frame.
REQ-020 SHALL hold uo_out stable between strobes.
REQ-021 SHALL, with ena low, freeze cnt, delay lines, accumulator and all outputs; no strobe.

Reset
REQ-022 SHALL, with rst_n high at a clk edge, clear cnt, delay lines, accumulator, latched steer (s=0), uo_out, and uio_out to 0.
REQ-023 SHALL give reset priority over ena.
REQ-024 SHALL abandon a partial window on reset mid-operation; the first strobe comes DECIM frames after reset release.

Configuration
REQ-025 SHALL honour macro BEAM_SATURATE_EN: defined -> uo_out = min(total, 255); undefined -> uo_out = total[8:1].

Structure
REQ-026 SHALL place the CLK_DIV/DECIM defaults, the delay-line depth (32) and the mic count (16) in shared package beamformer_pkg.
REQ-027 SHALL implement the per-mic shift register and tap mux as sub-module mic_delay_line, instantiated 16 times.

Verification
REQ-028 Reset: rst_n=1 for 2 cycles -> uo_out=0, uio_out=0, uio_oe=8'h03.
REQ-029 ui_in=8'hFF, s=0, defaults, macro defined -> strobe every 128 clk; uo_out=255 (saturated 256); macro undefined -> 128.
REQ-030 ui_in=8'h0F, s=0 -> mics 0..7 high, pop=8 -> uo_out=128 each window; ui_in=8'h00 -> 0.
REQ-031 s=0, all mics high only in the last frame of a window -> uo_out 16 then 0; s=4 (d_i=i), same impulse -> 1 then 15.
REQ-032 ena=0 for 200 clk mid-window -> uo_out and uio_out constant, no strobe; resume -> next strobe delayed by 200 clk.
REQ-033 s=-4 -> d_15=0, d_0=15; pdm_clk period 8 clk with 50% duty.
